// File: rtl/img_sel_ctrl.sv
// -----------------------------------------------------------------------------
// img_sel_ctrl
//
// Turns the debounced one-cycle button pulses into image-load commands for the
// frame loader. It tracks the current image index with wrap-around and runs a
// slideshow timer. A one-entry pending slot holds the most recent event that
// arrives while a load is in flight or before the power-up load has been issued.
//
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-low reset
//   next_flag  in   pulse: advance one image (highest priority)
//   prev_flag  in   pulse: go back one image
//   mode_flag  in   pulse: toggle slideshow mode (not a load event)
//   load_ack   in   frame loader finished loading img_idx
//   load_req   out  load request, level held until acked
//   img_idx    out  image to display/load
//   slideshow  out  1 = slideshow mode active
//   busy       out  1 = controller is not idle
//   dbg_state  out  current controller state (INIT=0, IDLE=1, REQ=2)
//
// Handshake: load_req is the valid, load_ack the ready. A transfer completes on
// the rising edge where both are high; load_req then drops for at least one
// cycle. img_idx is stable while load_req is high. load_ack is ignored while
// load_req is low.
// -----------------------------------------------------------------------------
module img_sel_ctrl #(
  parameter int NUM_IMG     = 4,
  parameter int IDX_W       = 2,
  parameter int SLIDE_TICKS = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             next_flag,
  input  logic             prev_flag,
  input  logic             mode_flag,
  input  logic             load_ack,
  output logic             load_req,
  output logic [IDX_W-1:0] img_idx,
  output logic             slideshow,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMG - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLIDE_TICKS - 1);

  state_t           r_state;
  logic             r_load_req;
  logic [IDX_W-1:0] r_idx;
  logic             r_slideshow;
  logic             r_busy;
  logic             r_pend_vld;
  logic             r_pend_prev;   // 1 = pending event is "prev", 0 = "next"
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic             w_req_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_pend_vld_nxt;
  logic             w_pend_prev_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tick;
  logic             w_ev_vld;
  logic             w_ev_prev;
  logic             w_go;
  logic             w_go_prev;

  // Event arbitration: next > prev > slide tick. A tick counts as "next".
  always_comb begin
    w_tick    = r_slideshow && (r_cnt == CNT_MAX);
    w_ev_vld  = next_flag | prev_flag | w_tick;
    w_ev_prev = ~next_flag & prev_flag;
  end

  // Slide counter: mode toggle, slideshow off, manual event or tick all
  // restart the period; otherwise count while slideshow is on.
  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (mode_flag || !r_slideshow || next_flag || prev_flag || w_tick) begin
      w_cnt_nxt = '0;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_load_req;
    w_idx_nxt       = r_idx;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_prev_nxt = r_pend_prev;
    w_go            = 1'b0;
    w_go_prev       = 1'b0;

    unique case (r_state)
      S_INIT: begin
        // Power-up load of the current (reset) index, no index change.
        w_state_nxt = S_REQ;
        w_req_nxt   = 1'b1;
        if (w_ev_vld) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_prev_nxt = w_ev_prev;
        end
      end
      S_IDLE: begin
        if (r_pend_vld) begin
          // Pending event wins; a fresh event this cycle takes its place.
          w_go           = 1'b1;
          w_go_prev      = r_pend_prev;
          w_pend_vld_nxt = 1'b0;
          if (w_ev_vld) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_prev_nxt = w_ev_prev;
          end
        end else if (w_ev_vld) begin
          w_go      = 1'b1;
          w_go_prev = w_ev_prev;
        end
      end
      S_REQ: begin
        if (load_ack) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
        end
        // Stored even on the ack edge so it is not lost.
        if (w_ev_vld) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_prev_nxt = w_ev_prev;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_req_nxt   = 1'b0;
      end
    endcase

    if (w_go) begin
      w_state_nxt = S_REQ;
      w_req_nxt   = 1'b1;
      if (w_go_prev) begin
        w_idx_nxt = (r_idx == '0) ? LAST_IDX : (r_idx - IDX_W'(1));
      end else begin
        w_idx_nxt = (r_idx == LAST_IDX) ? '0 : (r_idx + IDX_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_INIT;
      r_load_req  <= 1'b0;
      r_idx       <= '0;
      r_slideshow <= 1'b0;
      r_busy      <= 1'b1;
      r_pend_vld  <= 1'b0;
      r_pend_prev <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_req  <= w_req_nxt;
      r_idx       <= w_idx_nxt;
      r_slideshow <= r_slideshow ^ mode_flag;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_prev <= w_pend_prev_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign load_req  = r_load_req;
  assign img_idx   = r_idx;
  assign slideshow = r_slideshow;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_img_sel_ctrl.sv
module tb_img_sel_ctrl;

  localparam int NUM_IMG     = 4;
  localparam int IDX_W       = 2;
  localparam int SLIDE_TICKS = 8;
  localparam int CNT_W       = 3;

  logic             clk;
  logic             clr;
  logic             next_flag;
  logic             prev_flag;
  logic             mode_flag;
  logic             load_ack;
  logic             load_req;
  logic [IDX_W-1:0] img_idx;
  logic             slideshow;
  logic             busy;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  img_sel_ctrl #(
    .NUM_IMG(NUM_IMG), .IDX_W(IDX_W), .SLIDE_TICKS(SLIDE_TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clr(clr),
    .next_flag(next_flag), .prev_flag(prev_flag), .mode_flag(mode_flag),
    .load_ack(load_ack), .load_req(load_req), .img_idx(img_idx),
    .slideshow(slideshow), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: has the power-up load been issued, is a load outstanding,
  // current index (modular arithmetic), slideshow, cycles into the period,
  // and a one-entry "last event wins" mailbox.
  bit  m_started = 0;
  bit  m_loading = 0;
  int  m_idx     = 0;
  bit  m_ss      = 0;
  int  m_cnt     = 0;
  bit  m_pend    = 0;
  bit  m_pend_prev = 0;
  logic [IDX_W-1:0] exp_q[$];

  function automatic void model_reset();
    m_started = 0; m_loading = 0; m_idx = 0; m_ss = 0; m_cnt = 0;
    m_pend = 0; m_pend_prev = 0;
    exp_q.delete();
  endfunction

  function automatic void model_start(bit go_prev);
    if (go_prev) m_idx = (m_idx + NUM_IMG - 1) % NUM_IMG;
    else         m_idx = (m_idx + 1) % NUM_IMG;
    m_loading = 1;
    exp_q.push_back(IDX_W'(m_idx));
  endfunction

  function automatic void model_step(bit nf, bit pf, bit mf, bit ack);
    bit tick, ev, evp, was_prev;
    int new_cnt;
    tick = m_ss && (m_cnt == SLIDE_TICKS - 1);
    ev   = nf || pf || tick;
    evp  = !nf && pf;
    new_cnt = (mf || !m_ss || nf || pf || tick) ? 0 : m_cnt + 1;
    if (!m_started) begin
      m_started = 1;
      m_loading = 1;
      exp_q.push_back(IDX_W'(m_idx));
      if (ev) begin m_pend = 1; m_pend_prev = evp; end
    end else if (m_loading) begin
      if (ack) m_loading = 0;
      if (ev) begin m_pend = 1; m_pend_prev = evp; end
    end else if (m_pend) begin
      was_prev = m_pend_prev;
      m_pend = 0;
      model_start(was_prev);
      if (ev) begin m_pend = 1; m_pend_prev = evp; end
    end else if (ev) begin
      model_start(evp);
    end
    m_cnt = new_cnt;
    m_ss  = m_ss ^ mf;
  endfunction

  // ---------------- compare process ----------------
  logic prev_req = 1'b0;
  always @(posedge clk) begin
    if (!clr) model_reset();
    else      model_step(next_flag, prev_flag, mode_flag, load_ack);
    #1;
    chk("load_req", load_req, m_loading);
    chk("img_idx", img_idx, m_idx);
    chk("slideshow", slideshow, m_ss);
    chk("busy", busy, (!m_started || m_loading));
    if (load_req && !prev_req) begin
      chk("sb_avail", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sb_idx", img_idx, exp_q.pop_front());
    end
    prev_req = load_req;
  end

  // ---------------- driver tasks ----------------
  task automatic req_ack(input bit nf, input bit pf, input int exp_idx, input string name);
    next_flag = nf; prev_flag = pf;
    @(negedge clk);
    next_flag = 0; prev_flag = 0;
    chk({name, "_req"}, load_req, 1);
    chk({name, "_idx"}, img_idx, exp_idx);
    load_ack = 1;
    @(negedge clk);
    load_ack = 0;
    chk({name, "_drop"}, load_req, 0);
    @(negedge clk);
  endtask

  task automatic auto_ack(input int n);
    for (int i = 0; i < n; i++) begin
      load_ack = load_req;
      @(negedge clk);
    end
    load_ack = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int found;
    int highs;
    clr = 0; next_flag = 0; prev_flag = 0; mode_flag = 0; load_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", load_req, 0);
    chk("rst_idx", img_idx, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ss", slideshow, 0);

    // Power-up load of image 0.
    clr = 1;
    @(negedge clk);
    chk("init_req", load_req, 1);
    chk("init_idx", img_idx, 0);
    load_ack = 1;
    @(negedge clk);
    load_ack = 0;
    chk("init_drop", load_req, 0);
    chk("init_busy", busy, 0);

    // Index walk with wrap in both directions.
    req_ack(1, 0, 1, "n1");
    req_ack(1, 0, 2, "n2");
    req_ack(1, 0, 3, "n3");
    req_ack(1, 0, 0, "wrap_next");
    req_ack(0, 1, 3, "wrap_prev");
    req_ack(1, 0, 0, "n4");
    req_ack(1, 0, 1, "n5");
    req_ack(1, 1, 2, "both");
    for (int i = 0; i < 3; i++) begin
      chk("no_second", load_req, 0);
      @(negedge clk);
    end

    // Events during REQ: last one wins and follows after a gap.
    prev_flag = 1;
    @(negedge clk);
    prev_flag = 0;
    chk("inreq_req", load_req, 1);
    chk("inreq_idx", img_idx, 1);
    prev_flag = 1;
    @(negedge clk);
    prev_flag = 0;
    @(negedge clk);
    next_flag = 1;
    @(negedge clk);
    next_flag = 0;
    chk("inreq_hold_idx", img_idx, 1);
    load_ack = 1;
    @(negedge clk);
    load_ack = 0;
    chk("gap_low", load_req, 0);
    @(negedge clk);
    chk("pend_req", load_req, 1);
    chk("pend_idx", img_idx, 2);
    load_ack = 1;
    @(negedge clk);
    load_ack = 0;
    chk("pend_drop", load_req, 0);
    @(negedge clk);
    chk("pend_idle", load_req, 0);
    chk("pend_busy", busy, 0);

    // Slideshow: first advance exactly SLIDE_TICKS cycles after the toggle.
    mode_flag = 1;
    @(negedge clk);
    mode_flag = 0;
    chk("ss_on", slideshow, 1);
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (load_req) begin found = k; break; end
    end
    chk("slide_period", found, SLIDE_TICKS);
    chk("slide_idx", img_idx, 3);
    auto_ack(30);
    mode_flag = 1;
    load_ack = load_req;
    @(negedge clk);
    mode_flag = 0;
    chk("ss_off", slideshow, 0);
    auto_ack(6);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (load_req) highs++;
      @(negedge clk);
    end
    chk("ss_off_quiet", highs, 0);

    // Reset mid-REQ with an event pending.
    next_flag = 1;
    @(negedge clk);
    next_flag = 0;
    prev_flag = 1;
    @(negedge clk);
    prev_flag = 0;
    #2 clr = 0;
    #1;
    chk("mid_rst_req", load_req, 0);
    chk("mid_rst_idx", img_idx, 0);
    chk("mid_rst_busy", busy, 1);
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    chk("post_rst_req", load_req, 1);
    chk("post_rst_idx", img_idx, 0);
    load_ack = 1;
    @(negedge clk);
    load_ack = 0;
    for (int i = 0; i < 5; i++) begin
      chk("no_stale", load_req, 0);
      @(negedge clk);
    end

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      next_flag = ($urandom_range(0, 7) == 0);
      prev_flag = ($urandom_range(0, 7) == 0);
      mode_flag = ($urandom_range(0, 39) == 0);
      load_ack  = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    next_flag = 0; prev_flag = 0; mode_flag = 0; load_ack = 0; clr = 1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
